// File: rtl/board_write_ctrl.sv
// ============================================================================
// Module   : board_write_ctrl
// Purpose  : Sequences one board-update pass over a single-port board RAM:
//            erases the ghost from its old tile, moves Pacman (wall check,
//            pellet accounting), re-reads the ghost's next tile to remember
//            what lies under it, draws the ghost, then reports collisions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_write_ctrl #(
    parameter int TILE_W   = 3,
    parameter int PELLET_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PELLET_W-1:0] init_pellets,
    input  logic                start,
    input  logic [9:0]          pac_old,
    input  logic [9:0]          pac_new,
    input  logic [9:0]          gh_old,
    input  logic [9:0]          gh_new,
    output logic [9:0]          mem_addr,
    output logic                mem_we,
    output logic [TILE_W-1:0]   mem_wdata,
    input  logic [TILE_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                done,
    output logic [9:0]          pac_pos,
    output logic                pellet_eaten,
    output logic [PELLET_W-1:0] pellets_left,
    output logic                collision
);

    // Board tile codes
    localparam logic [TILE_W-1:0] T_EMPTY  = TILE_W'(0);
    localparam logic [TILE_W-1:0] T_WALL   = TILE_W'(1);
    localparam logic [TILE_W-1:0] T_PELLET = TILE_W'(2);
    localparam logic [TILE_W-1:0] T_PACMAN = TILE_W'(3);
    localparam logic [TILE_W-1:0] T_GHOST  = TILE_W'(4);

    // Pacman's home tile after reset
    localparam logic [9:0] PAC_HOME = 10'd495;

    // Pass sequencer states
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] GH_ERASE = 4'd1;
    localparam logic [3:0] PAC_RD   = 4'd2;
    localparam logic [3:0] PAC_WAIT = 4'd3;
    localparam logic [3:0] PAC_CLR  = 4'd4;
    localparam logic [3:0] PAC_WR   = 4'd5;
    localparam logic [3:0] GH_RD    = 4'd6;
    localparam logic [3:0] GH_WAIT  = 4'd7;
    localparam logic [3:0] GH_WR    = 4'd8;
    localparam logic [3:0] DONE     = 4'd9;

    logic [3:0]        state;
    logic [9:0]        lat_pac_old;
    logic [9:0]        lat_pac_new;
    logic [9:0]        lat_gh_old;
    logic [9:0]        lat_gh_new;
    logic [TILE_W-1:0] under_ghost;

    assign busy         = (state != IDLE);
    assign pellet_eaten = (state == PAC_WAIT) && (mem_rdata == T_PELLET);

    // Sequencer, latched positions, pellet counter and pass results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lat_pac_old  <= 10'd0;
            lat_pac_new  <= 10'd0;
            lat_gh_old   <= 10'd0;
            lat_gh_new   <= 10'd0;
            under_ghost  <= T_EMPTY;
            pac_pos      <= PAC_HOME;
            pellets_left <= '0;
            collision    <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // load wins over a simultaneous start
                    if (load) begin
                        pellets_left <= init_pellets;
                    end else if (start) begin
                        lat_pac_old <= pac_old;
                        lat_pac_new <= pac_new;
                        lat_gh_old  <= gh_old;
                        lat_gh_new  <= gh_new;
                        collision   <= 1'b0;
                        state       <= GH_ERASE;
                    end
                end
                GH_ERASE: state <= PAC_RD;
                PAC_RD:   state <= PAC_WAIT;
                PAC_WAIT: begin
                    if (mem_rdata == T_WALL) begin
                        state <= GH_RD;
                    end else begin
                        if ((mem_rdata == T_PELLET) && (pellets_left != '0)) begin
                            pellets_left <= pellets_left - PELLET_W'(1);
                        end
                        state <= PAC_CLR;
                    end
                end
                PAC_CLR:  state <= PAC_WR;
                PAC_WR: begin
                    pac_pos <= lat_pac_new;
                    state   <= GH_RD;
                end
                GH_RD:    state <= GH_WAIT;
                GH_WAIT: begin
                    // Never remember an actor as the tile under the ghost
                    if ((mem_rdata == T_PACMAN) || (mem_rdata == T_GHOST)) begin
                        under_ghost <= T_EMPTY;
                    end else begin
                        under_ghost <= mem_rdata;
                    end
                    state <= GH_WR;
                end
                GH_WR:    state <= DONE;
                DONE: begin
                    done      <= 1'b1;
                    collision <= (lat_gh_new == pac_pos) ||
                                 ((lat_gh_new == lat_pac_old) && (lat_gh_old == pac_pos));
                    state     <= IDLE;
                end
                default:  state <= IDLE;
            endcase
        end
    end

    // RAM port drive decoded from the current state
    always_comb begin
        mem_addr  = 10'd0;
        mem_we    = 1'b0;
        mem_wdata = T_EMPTY;
        case (state)
            GH_ERASE: begin
                mem_addr  = lat_gh_old;
                mem_we    = 1'b1;
                mem_wdata = under_ghost;
            end
            PAC_RD:   mem_addr = lat_pac_new;
            PAC_CLR: begin
                mem_addr  = lat_pac_old;
                mem_we    = 1'b1;
                mem_wdata = T_EMPTY;
            end
            PAC_WR: begin
                mem_addr  = lat_pac_new;
                mem_we    = 1'b1;
                mem_wdata = T_PACMAN;
            end
            GH_RD:    mem_addr = lat_gh_new;
            GH_WR: begin
                mem_addr  = lat_gh_new;
                mem_we    = 1'b1;
                mem_wdata = T_GHOST;
            end
            default: begin
                mem_addr  = 10'd0;
                mem_we    = 1'b0;
                mem_wdata = T_EMPTY;
            end
        endcase
    end

endmodule

`default_nettype wire
